// File: rtl/fft_bitrev_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bitrev_loader
//  Description : FFT input stage. Collects one frame of N complex samples into
//                bit-reversed order, then drains it as N/2 stage-0 operand
//                pairs (a = mem[2k], b = mem[2k+1]) over a valid/ready link.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_bitrev_loader #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DATA_W-1:0]   i_data_r,
    input  logic [DATA_W-1:0]   i_data_c,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   o_data_ra,
    output logic [DATA_W-1:0]   o_data_ca,
    output logic [DATA_W-1:0]   o_data_rb,
    output logic [DATA_W-1:0]   o_data_cb,
    output logic [LOG2N-2:0]    o_pair_idx,
    output logic                o_frame_done
);

    localparam int N     = 2 ** LOG2N;
    localparam int NPAIR = N / 2;
    localparam int PW    = LOG2N - 1;

    typedef enum logic [0:0] {
        S_LOAD  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // Single frame buffer; each word holds {real, imag}
    logic [2*DATA_W-1:0] mem [N];

    state_t              state_q,    state_d;
    logic [LOG2N-1:0]    in_cnt_q,   in_cnt_d;
    logic [LOG2N-1:0]    pair_cnt_q, pair_cnt_d;   // pairs already loaded, 0..N/2
    logic                valid_q,    valid_d;
    logic                done_q,     done_d;
    logic [DATA_W-1:0]   ra_q, ra_d, ca_q, ca_d, rb_q, rb_d, cb_q, cb_d;
    logic [PW-1:0]       idx_q,      idx_d;

    logic                w_accept;
    logic                w_xfer;
    logic                w_pairs_left;
    logic                w_load;
    logic                w_last_xfer;
    logic [LOG2N-1:0]    w_wr_addr;
    logic [LOG2N-1:0]    w_rd_addr_a;
    logic [LOG2N-1:0]    w_rd_addr_b;
    logic [2*DATA_W-1:0] w_word_a;
    logic [2*DATA_W-1:0] w_word_b;

    // Reverse the LOG2N address bits
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = x[LOG2N-1-i];
        end
        return r;
    endfunction

    assign w_accept     = i_valid && (state_q == S_LOAD);
    assign w_wr_addr    = bitrev(in_cnt_q);
    assign w_xfer       = valid_q && i_ready;
    assign w_pairs_left = (pair_cnt_q != LOG2N'(NPAIR));
    // Output register refills whenever it is empty or being emptied this edge
    assign w_load       = (state_q == S_DRAIN) && (!valid_q || i_ready) && w_pairs_left;
    assign w_last_xfer  = (state_q == S_DRAIN) && w_xfer && (idx_q == PW'(NPAIR - 1));
    assign w_rd_addr_a  = {pair_cnt_q[PW-1:0], 1'b0};
    assign w_rd_addr_b  = {pair_cnt_q[PW-1:0], 1'b1};
    assign w_word_a     = mem[w_rd_addr_a];
    assign w_word_b     = mem[w_rd_addr_b];

    // Buffer write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem[w_wr_addr] <= {i_data_r, i_data_c};
        end
    end

    // Next-state logic for the load/drain sequencer and the output register
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        pair_cnt_d = pair_cnt_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        ra_d       = ra_q;
        ca_d       = ca_q;
        rb_d       = rb_q;
        cb_d       = cb_q;
        idx_d      = idx_q;

        case (state_q)
            S_LOAD: begin
                if (w_accept) begin
                    if (in_cnt_q == LOG2N'(N - 1)) begin
                        state_d  = S_DRAIN;
                        in_cnt_d = '0;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (w_load) begin
                    ra_d       = w_word_a[2*DATA_W-1:DATA_W];
                    ca_d       = w_word_a[DATA_W-1:0];
                    rb_d       = w_word_b[2*DATA_W-1:DATA_W];
                    cb_d       = w_word_b[DATA_W-1:0];
                    idx_d      = pair_cnt_q[PW-1:0];
                    valid_d    = 1'b1;
                    pair_cnt_d = pair_cnt_q + 1'b1;
                end else if (w_xfer) begin
                    valid_d = 1'b0;
                end
                // Final pair leaves: hand the buffer back to the loader
                if (w_last_xfer) begin
                    valid_d    = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_LOAD;
                    pair_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            in_cnt_q   <= '0;
            pair_cnt_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ra_q       <= '0;
            ca_q       <= '0;
            rb_q       <= '0;
            cb_q       <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            pair_cnt_q <= pair_cnt_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ra_q       <= ra_d;
            ca_q       <= ca_d;
            rb_q       <= rb_d;
            cb_q       <= cb_d;
            idx_q      <= idx_d;
        end
    end

    assign o_ready      = (state_q == S_LOAD);
    assign o_valid      = valid_q;
    assign o_frame_done = done_q;
    assign o_data_ra    = ra_q;
    assign o_data_ca    = ca_q;
    assign o_data_rb    = rb_q;
    assign o_data_cb    = cb_q;
    assign o_pair_idx   = idx_q;

endmodule
`default_nettype wire
